// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle main control FSM for the RISC-V core.
// Sequences the shared ULA, memory port, IR, PC and register file for
// R-type, lw, sw and beq. Any other opcode, or a memory access that waits
// too long, parks the FSM in a sticky TRAP state that only reset leaves.
module controle_multiciclo #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       instr_done,
   output logic       trap,
   output logic       bus_err,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_ADDR   = 4'd2,
      S_MEM_RD = 4'd3,
      S_MEM_WB = 4'd4,
      S_MEM_WR = 4'd5,
      S_EXEC_R = 4'd6,
      S_R_WB   = 4'd7,
      S_BRANCH = 4'd8,
      S_TRAP   = 4'd9
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Counter wide enough to reach MEM_TIMEOUT-1; it saturates at all-ones.
   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] WAIT_MAX   = {CW{1'b1}};

   state_t          state_q;
   logic [CW-1:0]   wait_cnt_q;
   logic [CW-1:0]   wait_cnt_d;
   logic            trap_q;
   logic            bus_err_q;
   logic            timeout_s;

   // Saturating increment and timeout detection for the memory wait states.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      timeout_s  = 1'b0;
      if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
      // mem_ready in the limit cycle still completes the access normally.
      if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT) && !mem_ready) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // State sequencing, wait counter and sticky trap flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         trap_q     <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  state_q    <= S_DECODE;
                  wait_cnt_q <= '0;
               end else if (timeout_s) begin
                  state_q   <= S_TRAP;
                  trap_q    <= 1'b1;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            S_DECODE: begin
               wait_cnt_q <= '0;
               case (opcode)
                  OP_LW, OP_SW: state_q <= S_ADDR;
                  OP_R:         state_q <= S_EXEC_R;
                  OP_BEQ:       state_q <= S_BRANCH;
                  default: begin
                     state_q <= S_TRAP;
                     trap_q  <= 1'b1;
                  end
               endcase
            end
            S_ADDR: begin
               // IR still holds the load/store opcode here.
               wait_cnt_q <= '0;
               case (opcode)
                  OP_LW:   state_q <= S_MEM_RD;
                  OP_SW:   state_q <= S_MEM_WR;
                  default: begin
                     state_q <= S_TRAP;
                     trap_q  <= 1'b1;
                  end
               endcase
            end
            S_MEM_RD: begin
               if (mem_ready) begin
                  state_q    <= S_MEM_WB;
                  wait_cnt_q <= '0;
               end else if (timeout_s) begin
                  state_q   <= S_TRAP;
                  trap_q    <= 1'b1;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            S_MEM_WR: begin
               if (mem_ready) begin
                  state_q    <= S_FETCH;
                  wait_cnt_q <= '0;
               end else if (timeout_s) begin
                  state_q   <= S_TRAP;
                  trap_q    <= 1'b1;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            S_MEM_WB: begin
               state_q    <= S_FETCH;
               wait_cnt_q <= '0;
            end
            S_EXEC_R: begin
               state_q    <= S_R_WB;
               wait_cnt_q <= '0;
            end
            S_R_WB: begin
               state_q    <= S_FETCH;
               wait_cnt_q <= '0;
            end
            S_BRANCH: begin
               state_q    <= S_FETCH;
               wait_cnt_q <= '0;
            end
            S_TRAP: begin
               state_q <= S_TRAP;
               trap_q  <= 1'b1;
            end
            default: begin
               state_q <= S_TRAP;
               trap_q  <= 1'b1;
            end
         endcase
      end
   end

   // Moore decode of the datapath controls; FETCH loads IR/PC only when memory answers.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      instr_done  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
               end else begin
                  IRWrite = 1'b0;
                  PCWrite = 1'b0;
               end
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
            end
            S_MEM_WR: begin
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               instr_done = mem_ready;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_R_WB: begin
               RegWrite   = 1'b1;
               ALUOp      = 2'b10;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 1'b1;
               instr_done  = 1'b1;
            end
            default: begin
               PCWrite = 1'b0;
            end
         endcase
      end else begin
         PCWrite = 1'b0;
      end
   end

   assign trap    = trap_q;
   assign bus_err = bus_err_q;
   assign state_o = state_q;

endmodule
